// File: rtl/dmod_seg_multi.sv
// Multi-window I/Q demodulation segment: accumulates adc*cos / adc*sin over up to NWIN sample windows per trigger.
// Latency: product registered 1 cycle after the sample, accumulated 1 cycle later; trigger-to-finish = 1 + D + 2 + N + 1 cycles.
// Backpressure: fifo_full stalls the per-window result drain; a word is written only on a cycle that sees fifo_full low.
//
// Ports: clk/rst_n (async active-low); posedge_sample_trig starts a record of cmd_smpl_depth samples;
// sample_valid qualifies adc_data/lo_cos/lo_sin; demoWin_start/demoWin_len hold per-window POSW fields;
// pstprc_win_num selects the active window count (clamped to NWIN). Results leave as
// pstprc_IQ_seq_o = {I,Q} with pstprc_fifo_wren / Pstprc_num; Pstprc_finish pulses at record end; busy = not IDLE.
module dmod_seg_multi #(
    parameter int DW   = 16,
    parameter int REFW = 16,
    parameter int ACCW = 32,
    parameter int NWIN = 12,
    parameter int POSW = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   posedge_sample_trig,
    input  logic [15:0]            cmd_smpl_depth,
    input  logic                   sample_valid,
    input  logic signed [DW-1:0]   adc_data,
    input  logic signed [REFW-1:0] lo_cos,
    input  logic signed [REFW-1:0] lo_sin,
    input  logic [NWIN*POSW-1:0]   demoWin_start,
    input  logic [NWIN*POSW-1:0]   demoWin_len,
    input  logic [3:0]             pstprc_win_num,
    input  logic                   fifo_full,
    output logic [2*ACCW-1:0]      pstprc_IQ_seq_o,
    output logic                   pstprc_fifo_wren,
    output logic [3:0]             Pstprc_num,
    output logic                   Pstprc_finish,
    output logic                   busy
);

    localparam int PW = DW + REFW;
    // Window compare width: wide enough for start+len without wrap and for the 16-bit sample counter.
    localparam int CW = (POSW + 1 > 16) ? POSW + 1 : 16;
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             depth_q, depth_d, cnt_q, cnt_d;
    logic [NWIN*POSW-1:0]    start_q, start_d, len_q, len_d;
    logic [3:0]              nwin_q, nwin_d, idx_q, idx_d;
    logic                    flush_q, flush_d;
    logic                    pvld_q, pvld_d;
    logic [NWIN-1:0]         pmask_q, pmask_d;
    logic signed [PW-1:0]    pi_q, pi_d, pq_q, pq_d;
    logic signed [ACCW-1:0]  acci_q [NWIN];
    logic signed [ACCW-1:0]  acci_d [NWIN];
    logic signed [ACCW-1:0]  accq_q [NWIN];
    logic signed [ACCW-1:0]  accq_d [NWIN];
    logic [2*ACCW-1:0]       iq_q, iq_d;
    logic                    wren_q, wren_d, finish_q, finish_d, busy_q, busy_d;
    logic [3:0]              num_q, num_d;

    logic [NWIN-1:0]         win_hit;
    logic signed [PW-1:0]    adc_x, cos_x, sin_x;

    // Add a sign-extended product to an accumulator, clamping at the signed ACCW limits.
    function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                        input logic signed [PW-1:0]   p);
        logic [ACCW:0] s;
        s = {a[ACCW-1], a} + {{(ACCW+1-PW){p[PW-1]}}, p};
        if (s[ACCW] != s[ACCW-1]) return s[ACCW] ? ACC_MIN : ACC_MAX;
        return s[ACCW-1:0];
    endfunction

    assign adc_x = PW'(adc_data);
    assign cos_x = PW'(lo_cos);
    assign sin_x = PW'(lo_sin);

    // Per-window membership of the current sample index; end bound is computed wide so it never wraps.
    always_comb begin
        logic [CW-1:0] st;
        logic [CW-1:0] en;
        st = '0;
        en = '0;
        win_hit = '0;
        for (int k = 0; k < NWIN; k++) begin
            st = CW'(start_q[k*POSW +: POSW]);
            en = st + CW'(len_q[k*POSW +: POSW]);
            win_hit[k] = (CW'(cnt_q) >= st) && (CW'(cnt_q) < en);
        end
    end

    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
        len_d    = len_q;
        nwin_d   = nwin_q;
        idx_d    = idx_q;
        flush_d  = flush_q;
        pvld_d   = 1'b0;
        pmask_d  = '0;
        pi_d     = adc_x * cos_x;
        pq_d     = adc_x * sin_x;
        acci_d   = acci_q;
        accq_d   = accq_q;
        iq_d     = iq_q;
        wren_d   = 1'b0;
        num_d    = num_q;
        finish_d = 1'b0;

        // Accumulate stage: product registered last cycle lands in every window it was tagged for.
        if (pvld_q) begin
            for (int k = 0; k < NWIN; k++) begin
                if (pmask_q[k]) begin
                    acci_d[k] = sat_add(acci_q[k], pi_q);
                    accq_d[k] = sat_add(accq_q[k], pq_q);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (posedge_sample_trig) begin
                    state_d = S_RUN;
                    depth_d = cmd_smpl_depth;
                    start_d = demoWin_start;
                    len_d   = demoWin_len;
                    nwin_d  = (pstprc_win_num > 4'(NWIN)) ? 4'(NWIN) : pstprc_win_num;
                    cnt_d   = '0;
                    for (int k = 0; k < NWIN; k++) begin
                        acci_d[k] = '0;
                        accq_d[k] = '0;
                    end
                end
            end
            S_RUN: begin
                if (depth_q == 16'd0) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b0;
                end else if (sample_valid) begin
                    pvld_d  = 1'b1;
                    pmask_d = win_hit;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q == depth_q - 16'd1) begin
                        state_d = S_FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                // Two cycles let the last sample pass the product and accumulate registers.
                if (flush_q) begin
                    state_d = (nwin_q == 4'd0) ? S_DONE : S_DRAIN;
                    idx_d   = '0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!fifo_full) begin
                    wren_d = 1'b1;
                    num_d  = idx_q;
                    iq_d   = {acci_q[idx_q], accq_q[idx_q]};
                    if (idx_q == nwin_q - 4'd1) state_d = S_DONE;
                    else                        idx_d   = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            depth_q  <= '0;
            cnt_q    <= '0;
            start_q  <= '0;
            len_q    <= '0;
            nwin_q   <= '0;
            idx_q    <= '0;
            flush_q  <= 1'b0;
            pvld_q   <= 1'b0;
            pmask_q  <= '0;
            pi_q     <= '0;
            pq_q     <= '0;
            for (int k = 0; k < NWIN; k++) begin
                acci_q[k] <= '0;
                accq_q[k] <= '0;
            end
            iq_q     <= '0;
            wren_q   <= 1'b0;
            num_q    <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            len_q    <= len_d;
            nwin_q   <= nwin_d;
            idx_q    <= idx_d;
            flush_q  <= flush_d;
            pvld_q   <= pvld_d;
            pmask_q  <= pmask_d;
            pi_q     <= pi_d;
            pq_q     <= pq_d;
            acci_q   <= acci_d;
            accq_q   <= accq_d;
            iq_q     <= iq_d;
            wren_q   <= wren_d;
            num_q    <= num_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign pstprc_IQ_seq_o  = iq_q;
    assign pstprc_fifo_wren = wren_q;
    assign Pstprc_num       = num_q;
    assign Pstprc_finish    = finish_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_dmod_seg_multi.sv
module tb_dmod_seg_multi;

    localparam int DW = 16, REFW = 16, ACCW = 32, NWIN = 12, POSW = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  trig = 1'b0;
    logic [15:0]           depth = '0;
    logic                  sample_valid = 1'b0;
    logic [DW-1:0]         adc_data = '0;
    logic [REFW-1:0]       lo_cos = '0, lo_sin = '0;
    logic [NWIN*POSW-1:0]  win_start = '0, win_len = '0;
    logic [3:0]            win_num = '0;
    logic                  fifo_full = 1'b0;
    logic [2*ACCW-1:0]     iq;
    logic                  wren;
    logic [3:0]            num;
    logic                  finish;
    logic                  busy;

    always #5 clk = ~clk;

    dmod_seg_multi #(.DW(DW), .REFW(REFW), .ACCW(ACCW), .NWIN(NWIN), .POSW(POSW)) dut (
        .clk(clk), .rst_n(rst_n), .posedge_sample_trig(trig), .cmd_smpl_depth(depth),
        .sample_valid(sample_valid), .adc_data(adc_data), .lo_cos(lo_cos), .lo_sin(lo_sin),
        .demoWin_start(win_start), .demoWin_len(win_len), .pstprc_win_num(win_num),
        .fifo_full(fifo_full), .pstprc_IQ_seq_o(iq), .pstprc_fifo_wren(wren),
        .Pstprc_num(num), .Pstprc_finish(finish), .busy(busy)
    );

    typedef struct packed {
        logic [3:0]  num;
        logic [63:0] iq;
    } word_t;

    word_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    words_seen = 0;
    int    fins_seen = 0;
    logic  full_at_edge = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input int i, input int q);
        return {i[31:0], q[31:0]};
    endfunction

    task automatic expect_word(input int n, input int i, input int q);
        word_t w;
        w.num = 4'(n);
        w.iq  = mk(i, q);
        exp_q.push_back(w);
    endtask

    task automatic clear_wins;
        win_start = '0;
        win_len   = '0;
    endtask

    task automatic set_win(input int k, input int s, input int l);
        win_start[k*POSW +: POSW] = POSW'(s);
        win_len[k*POSW +: POSW]   = POSW'(l);
    endtask

    task automatic set_data(input int a, input int c, input int s);
        adc_data = 16'(a);
        lo_cos   = 16'(c);
        lo_sin   = 16'(s);
    endtask

    // Returns 1ns after the edge that samples the trigger.
    task automatic fire;
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
    endtask

    task automatic wait_fin(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!finish && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!finish) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no finish pulse after %0d cycles, required one", name, budget);
        end
    endtask

    // Monitor / scoreboard: pops one expected word per write strobe.
    always @(posedge clk) full_at_edge <= fifo_full;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wren) begin
                words_seen++;
                chk("wren_while_full", 64'(full_at_edge), 64'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got num %0d iq %0h, required no word", num, iq);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_num", 64'(num), 64'(w.num));
                    chk("word_iq", iq, w.iq);
                end
            end
            if (finish) begin
                fins_seen++;
                chk("words_pending_at_finish", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time budget exceeded, required completion");
        $fatal(1);
    end

    initial begin
        int cyc, f0, w0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_iq", iq, 64'd0);
        chk("reset_wren", 64'(wren), 64'd0);
        chk("reset_num", 64'(num), 64'd0);
        chk("reset_finish", 64'(finish), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        sample_valid = 1'b1;

        // Constant input, two basic windows: latency 16 + 2 + 3 = 21 edges
        clear_wins(); set_win(0, 0, 4); set_win(1, 8, 8);
        depth = 16; win_num = 2; set_data(100, 2, -1);
        expect_word(0, 800, -400); expect_word(1, 1600, -800);
        f0 = fins_seen;
        fire();
        chk("t1_busy", 64'(busy), 64'd1);
        wait_fin("t1", 100, cyc);
        chk("t1_latency", 64'(cyc), 64'd21);
        repeat (2) @(posedge clk);
        chk("t1_finish_count", 64'(fins_seen - f0), 64'd1);

        // Overlap and truncation at depth
        clear_wins(); set_win(0, 2, 6); set_win(1, 4, 100);
        depth = 10; win_num = 2; set_data(1, 1, 1);
        expect_word(0, 6, 6); expect_word(1, 6, 6);
        fire();
        wait_fin("t2", 100, cyc);
        chk("t2_latency", 64'(cyc), 64'd15);
        repeat (2) @(posedge clk);

        // Saturation, positive then negative
        clear_wins(); set_win(0, 0, 4);
        depth = 4; win_num = 1; set_data(32767, 32767, 0);
        expect_word(0, 32'sh7FFFFFFF, 0);
        fire();
        wait_fin("t3a", 100, cyc);
        repeat (2) @(posedge clk);
        set_data(32767, -32768, 1);
        expect_word(0, 32'sh80000000, 131068);
        fire();
        wait_fin("t3b", 100, cyc);
        repeat (2) @(posedge clk);

        // Backpressure: full through 5 DRAIN cycles (DRAIN entered at trigger edge + 8)
        clear_wins(); set_win(0, 0, 1); set_win(1, 1, 2); set_win(2, 0, 6);
        depth = 6; win_num = 3; set_data(2, 3, 4);
        expect_word(0, 6, 8); expect_word(1, 12, 16); expect_word(2, 36, 48);
        w0 = words_seen;
        fifo_full = 1'b1;
        fire();
        repeat (12) @(posedge clk);
        #1;
        chk("t4_no_words_while_full", 64'(words_seen - w0), 64'd0);
        @(posedge clk); #1 fifo_full = 1'b0;
        wait_fin("t4", 100, cyc);
        chk("t4_stall_latency", 64'(13 + cyc), 64'd17);
        repeat (2) @(posedge clk);
        chk("t4_word_count", 64'(words_seen - w0), 64'd3);

        // N = 0: no words, finish after FLUSH + DONE (5 + 0 + 3 edges)
        clear_wins(); set_win(0, 0, 5);
        depth = 5; win_num = 0; set_data(7, 7, 7);
        w0 = words_seen;
        fire();
        wait_fin("t5a", 100, cyc);
        chk("t5a_latency", 64'(cyc), 64'd8);
        repeat (2) @(posedge clk);
        chk("t5a_word_count", 64'(words_seen - w0), 64'd0);

        // Trigger during RUN is ignored
        clear_wins(); set_win(0, 0, 10);
        depth = 10; win_num = 1; set_data(1, 2, 3);
        expect_word(0, 20, 30);
        w0 = words_seen; f0 = fins_seen;
        fire();
        repeat (3) @(posedge clk);
        #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
        wait_fin("t5b", 100, cyc);
        chk("t5b_latency", 64'(4 + cyc), 64'd14);
        repeat (20) @(posedge clk);
        #1;
        chk("t5b_idle_after", 64'(busy), 64'd0);
        chk("t5b_finish_count", 64'(fins_seen - f0), 64'd1);
        chk("t5b_word_count", 64'(words_seen - w0), 64'd1);

        // Window count 15 clamps to 12
        clear_wins();
        for (int k = 0; k < NWIN; k++) set_win(k, k, 1);
        depth = 12; win_num = 15; set_data(3, 5, -7);
        for (int k = 0; k < NWIN; k++) expect_word(k, 15, -21);
        w0 = words_seen;
        fire();
        wait_fin("t5c", 200, cyc);
        chk("t5c_latency", 64'(cyc), 64'd27);
        repeat (2) @(posedge clk);
        chk("t5c_word_count", 64'(words_seen - w0), 64'd12);

        // Reset mid-RUN: outputs clear immediately, nothing further emitted
        clear_wins(); set_win(0, 0, 20);
        depth = 20; win_num = 1; set_data(1, 1, 1);
        f0 = fins_seen; w0 = words_seen;
        fire();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_iq", iq, 64'd0);
        chk("rst_wren", 64'(wren), 64'd0);
        chk("rst_num", 64'(num), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_no_finish", 64'(fins_seen - f0), 64'd0);
        chk("rst_no_words", 64'(words_seen - w0), 64'd0);

        // Fresh record after reset
        clear_wins(); set_win(0, 1, 2);
        depth = 4; win_num = 1; set_data(-5, 7, 9);
        expect_word(0, -70, -90);
        fire();
        wait_fin("t6", 100, cyc);
        chk("t6_latency", 64'(cyc), 64'd8);
        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty_end", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
